// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg -- shared definitions for the sequential ALU core.
//
// Contents:
//   OP_AND..OP_MUL  3-bit opcode constants (110/111 are illegal)
//   state_t         control FSM state encoding (ST_MULT only exists when the
//                   multiplier is built, i.e. with ALU_SEQ_MULT_EN defined)
//   flags_t         carry / zero / err flag bundle, independent of WIDTH
//   FLAGS_CLEAR     all flags low (reset value)
//   FLAGS_ILLEGAL   flag pattern presented for an illegal opcode
//   op_is_mul()     opcode decode for the multiplier (ALU_SEQ_MULT_EN only)
//
// Configuration macro: ALU_SEQ_MULT_EN
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef ALU_SEQ_MULT_EN
        ST_MULT = 2'd1,
`endif
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic err;
    } flags_t;

    localparam flags_t FLAGS_CLEAR   = '{carry: 1'b0, zero: 1'b0, err: 1'b0};
    localparam flags_t FLAGS_ILLEGAL = '{carry: 1'b0, zero: 1'b1, err: 1'b1};

`ifdef ALU_SEQ_MULT_EN
    function automatic logic op_is_mul(input logic [2:0] op);
        return op == OP_MUL;
    endfunction
`endif

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if -- request/response bundle of the sequential ALU core.
//
// Signals:
//   in_valid/in_ready          request handshake
//   op[2:0], a, b              opcode and WIDTH-bit operands
//   out_valid/out_ready        response handshake
//   result[2*WIDTH-1:0]        operation result
//   carry, zero, err           result flags
//
// Modports:
//   master  requester/consumer side (drives request, accepts response)
//   slave   ALU side (accepts request, drives response)
// -----------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result;
    logic                   carry;
    logic                   zero;
    logic                   err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, zero, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, zero, err
    );
endinterface

// File: rtl/alu_seq_mult.sv
// -----------------------------------------------------------------------------
// alu_seq_mult -- shift-add unsigned multiplier, one partial product per cycle.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (aborts any operation)
//   start_i       latch a_i/b_i and begin a new multiplication
//   a_i, b_i      WIDTH-bit unsigned operands
//   done_o        high during the final step; product_o is the full product
//   product_o     2*WIDTH-bit product (final only while done_o is high)
//
// The final partial product is added combinationally onto product_o so the
// caller can register the complete result on the same edge as the last step.
// Only instantiated when ALU_SEQ_MULT_EN is defined.
// -----------------------------------------------------------------------------
module alu_seq_mult #(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);
    localparam int CW = $clog2(WIDTH);

    logic                 busy_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_d;

    // Multiplicand shifts left and multiplier shifts right every step, so the
    // current partial product always depends on mplier_q[0] only.
    assign partial   = mplier_q[0] ? mcand_q : '0;
    assign acc_d     = acc_q + partial;
    assign product_o = acc_d;
    assign done_o    = busy_q && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq_core.sv
// -----------------------------------------------------------------------------
// alu_seq_core -- valid/ready ALU with 1-cycle logic/arith ops and an optional
//                 sequential shift-add multiplier.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset, aborts any operation in flight
//   bus (slave)   alu_seq_if: in_valid/in_ready, op, a, b,
//                 out_valid/out_ready, result, carry, zero, err
//
// Opcodes: AND, OR, XOR, ADD, SUB (latency 1), MUL (latency WIDTH+1),
//          110/111 illegal (result 0, zero=1, err=1, latency 1).
//
// Configuration macro: ALU_SEQ_MULT_EN
//   defined   -> MUL implemented via alu_seq_mult, ST_MULT state present
//   undefined -> opcode 101 handled as illegal, no multiplier logic
// -----------------------------------------------------------------------------
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int RW = 2 * WIDTH;

    state_t             state_q;
    logic               out_valid_q;
    logic [RW-1:0]      result_q;
    flags_t             flags_q;

    logic               in_ready;
    logic               in_fire;
    logic               out_fire;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [RW-1:0]      alu_result_d;
    flags_t             alu_flags_d;

    // Accept in IDLE, or in HOLD when the held result retires this same cycle.
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    // Single-cycle datapath. MUL also lands in the default branch here, but
    // when the multiplier exists the FSM never registers these values for it.
    always_comb begin
        sum          = {1'b0, bus.a} + {1'b0, bus.b};
        diff         = {1'b0, bus.a} - {1'b0, bus.b};
        alu_result_d = '0;
        alu_flags_d  = FLAGS_CLEAR;
        case (bus.op)
            OP_AND: alu_result_d[WIDTH-1:0] = bus.a & bus.b;
            OP_OR:  alu_result_d[WIDTH-1:0] = bus.a | bus.b;
            OP_XOR: alu_result_d[WIDTH-1:0] = bus.a ^ bus.b;
            OP_ADD: begin
                alu_result_d[WIDTH:0] = sum;
                alu_flags_d.carry     = sum[WIDTH];
            end
            OP_SUB: begin
                // Extra top bit of the widened difference is the borrow (a < b).
                alu_result_d[WIDTH-1:0] = diff[WIDTH-1:0];
                alu_flags_d.carry       = diff[WIDTH];
            end
            default: alu_flags_d = FLAGS_ILLEGAL;
        endcase
        if (!alu_flags_d.err) begin
            alu_flags_d.zero = (alu_result_d == '0);
        end
    end

`ifdef ALU_SEQ_MULT_EN
    logic            mult_start;
    logic            mult_done;
    logic [RW-1:0]   mult_product;

    assign mult_start = in_fire && op_is_mul(bus.op);

    alu_seq_mult #(
        .WIDTH     (WIDTH)
    ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mult_start),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .done_o    (mult_done),
        .product_o (mult_product)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= FLAGS_CLEAR;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (in_fire) begin
`ifdef ALU_SEQ_MULT_EN
                        if (op_is_mul(bus.op)) begin
                            state_q     <= ST_MULT;
                            out_valid_q <= 1'b0;
                        end else
`endif
                        begin
                            state_q     <= ST_HOLD;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_result_d;
                            flags_q     <= alu_flags_d;
                        end
                    end else if (out_fire) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
`ifdef ALU_SEQ_MULT_EN
                ST_MULT: begin
                    if (mult_done) begin
                        state_q       <= ST_HOLD;
                        out_valid_q   <= 1'b1;
                        result_q      <= mult_product;
                        flags_q.carry <= |mult_product[RW-1:WIDTH];
                        flags_q.zero  <= (mult_product == '0);
                        flags_q.err   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = flags_q.carry;
    assign bus.zero      = flags_q.zero;
    assign bus.err       = flags_q.err;
endmodule

// File: tb/tb_alu_seq_core.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_core -- self-checking bench for alu_seq_core.
// u_dut2 (WIDTH=2) is driven through a scoreboard: expected results are pushed
// when a request is accepted and popped when the response retires. u_dut4
// (WIDTH=4) covers reset abort of a long operation.
// Honors ALU_SEQ_MULT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_seq_core;
    logic clk = 1'b0;
    logic rst2;
    logic rst4;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_if #(.WIDTH(2)) if2 ();
    alu_seq_if #(.WIDTH(4)) if4 ();

    alu_seq_core #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(if2));
    alu_seq_core #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4));

`ifdef ALU_SEQ_MULT_EN
    localparam logic MUL_BUSY_READY = 1'b0;
`else
    localparam logic MUL_BUSY_READY = 1'b1;
`endif

    typedef struct {
        logic [3:0] res;
        logic       carry;
        logic       zero;
        logic       err;
        int         lat;
        int         stamp;
    } exp_t;

    exp_t sb_q[$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model for WIDTH=2, written from the opcode definitions.
    function automatic exp_t model(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        exp_t e;
        int   ai = int'(a);
        int   bi = int'(b);
        int   r  = 0;
        e.carry = 1'b0;
        e.err   = 1'b0;
        e.lat   = 1;
        e.stamp = 0;
        case (op)
            3'b000: r = ai & bi;
            3'b001: r = ai | bi;
            3'b010: r = ai ^ bi;
            3'b011: begin r = ai + bi; e.carry = (r > 3); end
            3'b100: begin r = (ai - bi) & 3; e.carry = (ai < bi); end
`ifdef ALU_SEQ_MULT_EN
            3'b101: begin r = ai * bi; e.carry = (r > 3); e.lat = 3; end
`endif
            default: e.err = 1'b1;
        endcase
        e.res  = r[3:0];
        e.zero = (r == 0);
        return e;
    endfunction

    task automatic push_exp(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        exp_t e;
        e = model(op, a, b);
        e.stamp = cyc;
        sb_q.push_back(e);
        $display("req  op=%0d a=%0d b=%0d exp res=%0h c=%0b z=%0b e=%0b lat=%0d",
                 op, a, b, e.res, e.carry, e.zero, e.err, e.lat);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        logic done = 1'b0;
        if2.in_valid = 1'b1;
        if2.op = op;
        if2.a  = a;
        if2.b  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (if2.in_ready) begin
                push_exp(op, a, b);
                done = 1'b1;
            end
        end
        if (!done) check_value("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check_value("drain_timeout", sb_q.size(), 32'd0);
    endtask

    // Response monitor: checks value + latency on first presentation,
    // stability while held, and that nothing is presented with an empty queue.
    initial begin : monitor
        logic seen = 1'b0;
        exp_t h;
        forever begin
            @(negedge clk);
            if (rst2) begin
                seen = 1'b0;
            end else if (sb_q.size() == 0) begin
                check_value("idle_no_valid", if2.out_valid, 32'd0);
            end else if (if2.out_valid) begin
                h = sb_q[0];
                if (!seen) begin
                    check_value("latency", cyc - h.stamp, h.lat);
                    check_value("result", if2.result, h.res);
                    check_value("carry", if2.carry, h.carry);
                    check_value("zero", if2.zero, h.zero);
                    check_value("err", if2.err, h.err);
                    $display("resp res=%0h c=%0b z=%0b e=%0b", if2.result, if2.carry, if2.zero, if2.err);
                    seen = 1'b1;
                end else begin
                    check_value("hold_result", if2.result, h.res);
                end
                if (if2.out_ready) begin
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin : driver
        logic accepted;
        rst2 = 1'b1;
        rst4 = 1'b1;
        if2.in_valid = 1'b0; if2.op = 3'b000; if2.a = 2'd0; if2.b = 2'd0; if2.out_ready = 1'b1;
        if4.in_valid = 1'b0; if4.op = 3'b000; if4.a = 4'd0; if4.b = 4'd0; if4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_out_valid", if2.out_valid, 32'd0);
        check_value("rst_result", if2.result, 32'd0);
        check_value("rst_carry", if2.carry, 32'd0);
        check_value("rst_zero", if2.zero, 32'd0);
        check_value("rst_err", if2.err, 32'd0);
        check_value("rst4_out_valid", if4.out_valid, 32'd0);
        @(posedge clk); #1;
        rst2 = 1'b0;
        @(negedge clk);
        check_value("post_rst_ready", if2.in_ready, 32'd1);
        @(posedge clk); #1;

        // ADD with carry, SUB borrow then XOR back-to-back.
        send(3'b011, 2'd3, 2'd1);
        drain();
        send(3'b100, 2'd1, 2'd2);
        send(3'b010, 2'd2, 2'd2);
        drain();

        // MUL: ready stays low while the multiplier runs.
        send(3'b101, 2'd3, 2'd3);
        @(negedge clk);
        check_value("mul_busy_ready1", if2.in_ready, MUL_BUSY_READY);
        @(negedge clk);
        check_value("mul_busy_ready2", if2.in_ready, MUL_BUSY_READY);
        @(posedge clk); #1;
        drain();

        // Back-pressure: OR held for 5 cycles, pending XOR not accepted.
        if2.out_ready = 1'b0;
        send(3'b001, 2'd1, 2'd2);
        if2.in_valid = 1'b1; if2.op = 3'b010; if2.a = 2'd3; if2.b = 2'd1;
        repeat (5) begin
            @(negedge clk);
            check_value("hold_in_ready", if2.in_ready, 32'd0);
        end
        @(posedge clk); #1;
        if2.out_ready = 1'b1;
        send(3'b010, 2'd3, 2'd1);
        drain();

        // Illegal opcodes and a few corner values.
        send(3'b111, 2'd3, 2'd2);
        send(3'b110, 2'd1, 2'd1);
        send(3'b000, 2'd3, 2'd2);
        send(3'b011, 2'd0, 2'd0);
        send(3'b100, 2'd3, 2'd3);
        drain();

        // Random traffic with random back-pressure.
        accepted = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if2.out_ready = ($urandom_range(0, 3) != 0);
            if (accepted) begin
                if2.in_valid = ($urandom_range(0, 2) != 0);
                if2.op = 3'($urandom_range(0, 7));
                if2.a  = 2'($urandom_range(0, 3));
                if2.b  = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            if (if2.in_valid && if2.in_ready) push_exp(if2.op, if2.a, if2.b);
            accepted = !if2.in_valid || if2.in_ready;
            @(posedge clk); #1;
        end
        if2.in_valid = 1'b0;
        if2.out_ready = 1'b1;
        drain();

        // WIDTH=4: reset in the middle of a 15*15 request aborts it.
        rst4 = 1'b0;
        if4.out_ready = 1'b0;
        if4.in_valid = 1'b1; if4.op = 3'b101; if4.a = 4'd15; if4.b = 4'd15;
        @(negedge clk);
        check_value("w4_mul_ready", if4.in_ready, 32'd1);
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        @(posedge clk); #1;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        if4.out_ready = 1'b1;
        @(negedge clk);
        check_value("w4_abort_ready", if4.in_ready, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_value("w4_abort_no_valid", if4.out_valid, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        if4.in_valid = 1'b1; if4.op = 3'b011; if4.a = 4'd1; if4.b = 4'd1;
        @(negedge clk);
        check_value("w4_add_ready", if4.in_ready, 32'd1);
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        @(negedge clk);
        check_value("w4_add_valid", if4.out_valid, 32'd1);
        check_value("w4_add_result", if4.result, 32'h02);
        check_value("w4_add_carry", if4.carry, 32'd0);
        check_value("w4_add_zero", if4.zero, 32'd0);
        check_value("w4_add_err", if4.err, 32'd0);
        $display("resp4 res=%0h c=%0b z=%0b e=%0b", if4.result, if4.carry, if4.zero, if4.err);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
